// File: rtl/mem_pkg.sv
// Shared definitions for the memory-side line responder: default geometry,
// the responder state encoding and width helpers.
package mem_pkg;

    localparam int DEFAULT_ARCH_BITS   = 32;
    localparam int DEFAULT_LINE_BITS   = 128;
    localparam int DEFAULT_MEM_LINES   = 4096;
    localparam int DEFAULT_MEM_LATENCY = 10;

    // Byte-offset bits inside a 16-byte line; the line index starts above these.
    localparam int LINE_OFFSET_BITS    = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RESP_RD = 3'd3,
        ST_RESP_WR = 3'd4
    } resp_state_t;

    // Width of a line index for an array of the given number of lines.
    function automatic int line_index_bits(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

    // Width of a down-counter that must hold latency-1.
    function automatic int latency_cnt_bits(input int latency);
        return (latency > 2) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Synchronous single-port line storage: one read or one write per cycle.
// A write takes priority; otherwise the addressed line is read into
// read_data and appears on the following cycle.
module mem_line_array
    import mem_pkg::*;
#(
    parameter int LINES      = DEFAULT_MEM_LINES,
    parameter int LINE_BITS  = DEFAULT_LINE_BITS,
    parameter int INDEX_BITS = line_index_bits(DEFAULT_MEM_LINES)
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] index,
    input  logic                  write_en,
    input  logic [LINE_BITS-1:0]  write_data,
    output logic [LINE_BITS-1:0]  read_data
);

    logic [LINE_BITS-1:0] mem [LINES];

    // Single port: store the line on a write, otherwise fetch the addressed line.
    // NOTE: storage and its read register carry no reset; clearing a RAM needs a
    // sweep, not a reset net, and contents must survive rst anyway.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[index] <= write_data;
        end else begin
            read_data <= mem[index];
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for the cache line bus. Accepts one line read or
// line write at a time, waits MEM_LATENCY cycles and answers with a
// one-cycle readDataValid / writeDone pulse.
// Build option: define MEMRESP_WRITE_EN to enable the write path; without it
// write requests are ignored, writeDone is tied low and the array is read-only.
module mem_line_responder
    import mem_pkg::*;
#(
    parameter int ARCH_BITS        = DEFAULT_ARCH_BITS,
    parameter int MEMORY_LINE_BITS = DEFAULT_LINE_BITS,
    parameter int MEM_LINES        = DEFAULT_MEM_LINES,
    parameter int MEM_LATENCY      = DEFAULT_MEM_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        readReq,
    input  logic [ARCH_BITS-1:0]        readAddr,
    input  logic                        writeReq,
    input  logic [ARCH_BITS-1:0]        writeAddr,
    input  logic [MEMORY_LINE_BITS-1:0] writeData,
    output logic [MEMORY_LINE_BITS-1:0] readData,
    output logic                        readDataValid,
    output logic                        writeDone,
    output logic                        busy
);

    localparam int INDEX_BITS = line_index_bits(MEM_LINES);
    localparam int CNT_BITS   = latency_cnt_bits(MEM_LATENCY);
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MEM_LATENCY - 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(1);

    resp_state_t                 state;
    logic [CNT_BITS-1:0]         counter;
    logic [INDEX_BITS-1:0]       line_index;
    logic [MEMORY_LINE_BITS-1:0] write_line;

    logic [INDEX_BITS-1:0]       rd_line_index;
    logic [INDEX_BITS-1:0]       wr_line_index;
    logic [INDEX_BITS-1:0]       array_index;
    logic                        array_write_en;
    logic [MEMORY_LINE_BITS-1:0] array_read_data;
    logic                        accept_write;
    logic                        accept_read;

    // Address bits above the index wrap; bits below it select bytes in the line.
    assign rd_line_index = readAddr[LINE_OFFSET_BITS +: INDEX_BITS];
    assign wr_line_index = writeAddr[LINE_OFFSET_BITS +: INDEX_BITS];

`ifdef MEMRESP_WRITE_EN
    // A write wins over a simultaneous read; the read stays asserted and is
    // picked up on the next return to IDLE.
    assign accept_write = (state == ST_IDLE) && writeReq;
    // Commit only from RESP_WR, and never on a reset edge so an aborted write
    // leaves the array untouched.
    assign array_write_en = (state == ST_RESP_WR) && !rst;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{readAddr, writeAddr};
`else
    assign accept_write   = 1'b0;
    assign array_write_en = 1'b0;
    assign writeDone      = 1'b0;

    logic unused_write_inputs;
    assign unused_write_inputs = ^{readAddr, writeAddr, writeReq};
`endif

    assign accept_read = (state == ST_IDLE) && readReq && !accept_write;

    // Point the array at the incoming request's line while idle, so a
    // one-cycle latency still has the line ready, and at the latched line after.
    // NOTE: every signal of an always_comb gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        array_index = line_index;
        if (state == ST_IDLE) begin
            array_index = accept_write ? wr_line_index : rd_line_index;
        end
    end

    // Capture the accepted request; later changes on the inputs are ignored.
    always_ff @(posedge clk) begin
        if (accept_write) begin
            line_index <= wr_line_index;
            write_line <= writeData;
        end else if (accept_read) begin
            line_index <= rd_line_index;
        end
    end

    // Access sequencer: accept, count down the latency, respond for one cycle.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            counter       <= '0;
            readData      <= '0;
            readDataValid <= 1'b0;
            busy          <= 1'b0;
`ifdef MEMRESP_WRITE_EN
            writeDone     <= 1'b0;
`endif
        end else begin
            readDataValid <= 1'b0;
`ifdef MEMRESP_WRITE_EN
            writeDone     <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (accept_write) begin
                        counter <= CNT_LOAD;
                        state   <= (MEM_LATENCY == 1) ? ST_RESP_WR : ST_WR_WAIT;
                        busy    <= 1'b1;
                    end else if (accept_read) begin
                        counter <= CNT_LOAD;
                        state   <= (MEM_LATENCY == 1) ? ST_RESP_RD : ST_RD_WAIT;
                        busy    <= 1'b1;
                    end
                end
                ST_RD_WAIT, ST_WR_WAIT: begin
                    counter <= counter - CNT_LAST;
                    if (counter == CNT_LAST) begin
                        state <= (state == ST_RD_WAIT) ? ST_RESP_RD : ST_RESP_WR;
                    end
                end
                ST_RESP_RD: begin
                    readData      <= array_read_data;
                    readDataValid <= 1'b1;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
`ifdef MEMRESP_WRITE_EN
                ST_RESP_WR: begin
                    writeDone <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_line_array #(
        .LINES      (MEM_LINES),
        .LINE_BITS  (MEMORY_LINE_BITS),
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk        (clk),
        .index      (array_index),
        .write_en   (array_write_en),
        .write_data (write_line),
        .read_data  (array_read_data)
    );

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: one instance at the default
// 10-cycle latency and one at latency 1. Follows MEMRESP_WRITE_EN the same
// way the design does.
module tb_mem_line_responder;

    localparam logic [127:0] D1 = 128'hDEADBEEF_00000001_00000002_00000003;
    localparam logic [127:0] D2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D3 = 128'h55AA55AA_12121212_34343434_56565656;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         rd_req = 1'b0;
    logic [31:0]  rd_addr = '0;
    logic         wr_req = 1'b0;
    logic [31:0]  wr_addr = '0;
    logic [127:0] wr_data = '0;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         wr_done;
    logic         busy;

    logic         b_rd_req = 1'b0;
    logic [31:0]  b_rd_addr = '0;
    logic         b_wr_req = 1'b0;
    logic [31:0]  b_wr_addr = '0;
    logic [127:0] b_wr_data = '0;
    logic [127:0] b_rd_data;
    logic         b_rd_valid;
    logic         b_wr_done;
    logic         b_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_line_responder #(.MEM_LATENCY(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .readReq       (rd_req),
        .readAddr      (rd_addr),
        .writeReq      (wr_req),
        .writeAddr     (wr_addr),
        .writeData     (wr_data),
        .readData      (rd_data),
        .readDataValid (rd_valid),
        .writeDone     (wr_done),
        .busy          (busy)
    );

    mem_line_responder #(.MEM_LATENCY(1), .MEM_LINES(256)) dut_fast (
        .clk           (clk),
        .rst           (rst),
        .readReq       (b_rd_req),
        .readAddr      (b_rd_addr),
        .writeReq      (b_wr_req),
        .writeAddr     (b_wr_addr),
        .writeData     (b_wr_data),
        .readData      (b_rd_data),
        .readDataValid (b_rd_valid),
        .writeDone     (b_wr_done),
        .busy          (b_busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a read and wait for its pulse; lat counts edges after acceptance.
    task automatic do_read(input logic [31:0] addr, output int lat, output int busy_cycles,
                           output logic [127:0] data);
        rd_addr = addr;
        rd_req  = 1'b1;
        lat = -1;
        busy_cycles = 0;
        data = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (busy) busy_cycles++;
            if (rd_valid) begin
                lat  = i - 1;
                data = rd_data;
                break;
            end
        end
        rd_req = 1'b0;
    endtask

`ifdef MEMRESP_WRITE_EN
    task automatic do_write(input logic [31:0] addr, input logic [127:0] line,
                            output int lat, output int busy_cycles);
        wr_addr = addr;
        wr_data = line;
        wr_req  = 1'b1;
        lat = -1;
        busy_cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (busy) busy_cycles++;
            if (wr_done) begin
                lat = i - 1;
                break;
            end
        end
        wr_req = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int lat_w;
        int lat_r;
        int busy_cycles;
        int pulses;
        int early;
        int t1;
        int t2;
        logic [127:0] data;

        repeat (3) tick();
        check("reset_rd_data", rd_data, '0);
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_wr_done", wr_done, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        tick();

        // Plain read from never-written memory.
        do_read(32'h0000_1000, lat, busy_cycles, data);
        check("rd_latency", lat, 10);
        check("rd_busy_cycles", busy_cycles, 10);
        check("rd_data_zero", data, '0);
        tick();
        check("rd_single_pulse", rd_valid, 1'b0);
        check("rd_busy_idle", busy, 1'b0);

`ifdef MEMRESP_WRITE_EN
        // Write a line, then read it back through a different byte offset.
        do_write(32'h0000_1010, D1, lat, busy_cycles);
        check("wr_latency", lat, 10);
        check("wr_busy_cycles", busy_cycles, 10);
        tick();
        check("wr_single_pulse", wr_done, 1'b0);
        do_read(32'h0000_101C, lat, busy_cycles, data);
        check("raw_latency", lat, 10);
        check("raw_data", data, D1);
        tick();
        // Upper address bits wrap onto the same line.
        do_read(32'h0001_1010, lat, busy_cycles, data);
        check("wrap_data", data, D1);
        tick();

        // Simultaneous write and read of one line: write first, read next.
        wr_addr = 32'h0000_3000;
        wr_data = D2;
        wr_req  = 1'b1;
        rd_addr = 32'h0000_3008;
        rd_req  = 1'b1;
        lat_w = -1;
        early = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rd_valid) early++;
            if (wr_done) begin
                lat_w = i - 1;
                break;
            end
        end
        wr_req = 1'b0;
        lat_r = -1;
        data = '0;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (rd_valid) begin
                lat_r = j;
                data  = rd_data;
                break;
            end
        end
        rd_req = 1'b0;
        check("both_wr_latency", lat_w, 10);
        check("both_no_early_read", early, 0);
        check("both_rd_after_done", lat_r, 11);
        check("both_rd_data", data, D2);
        tick();

        // Reset four cycles into a write: no commit, no pulse.
        wr_addr = 32'h0000_2000;
        wr_data = D3;
        wr_req  = 1'b1;
        repeat (4) tick();
        rst    = 1'b1;
        wr_req = 1'b0;
        tick();
        check("abort_rd_data", rd_data, '0);
        check("abort_rd_valid", rd_valid, 1'b0);
        check("abort_wr_done", wr_done, 1'b0);
        check("abort_busy", busy, 1'b0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wr_done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        do_read(32'h0000_2000, lat, busy_cycles, data);
        check("abort_array_unchanged", data, '0);
        tick();
`else
        // Write requests are ignored entirely.
        wr_addr = 32'h0000_1010;
        wr_data = D1;
        wr_req  = 1'b1;
        pulses = 0;
        busy_cycles = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (wr_done) pulses++;
            if (busy) busy_cycles++;
        end
        wr_req = 1'b0;
        check("nowr_done", pulses, 0);
        check("nowr_busy", busy_cycles, 0);
        do_read(32'h0000_101C, lat, busy_cycles, data);
        check("nowr_array_unchanged", data, '0);
        tick();

        // With both requests up the read is served as if alone.
        wr_req = 1'b1;
        do_read(32'h0000_3000, lat, busy_cycles, data);
        check("nowr_both_latency", lat, 10);
        check("nowr_both_wr_done", wr_done, 1'b0);
        wr_req = 1'b0;
        tick();

        // Reset four cycles into a read: no pulse afterwards.
        rd_addr = 32'h0000_2000;
        rd_req  = 1'b1;
        repeat (4) tick();
        rst    = 1'b1;
        rd_req = 1'b0;
        tick();
        check("abort_rd_valid", rd_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
`endif

        // Latency 1: back-to-back reads, pulses at N+1 and N+3.
        b_rd_addr = 32'h0000_1000;
        b_rd_req  = 1'b1;
        t1 = -1;
        t2 = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (b_rd_valid) begin
                if (t1 < 0) begin
                    t1 = i - 1;
                    b_rd_addr = 32'h0000_1010;
                end else begin
                    t2 = i - 1;
                    b_rd_req = 1'b0;
                    break;
                end
            end
        end
        b_rd_req = 1'b0;
        check("lat1_first_valid", t1, 1);
        check("lat1_second_valid", t2, 3);
        check("lat1_data", b_rd_data, '0);
        tick();
        check("lat1_idle", b_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Memory-side responder for the cache line bus: accepts line-read requests from the instruction cache (and line writes from a future data cache), models fixed access latency, and returns 128-bit lines with a one-cycle valid pulse. It sits below `cacheIns`, at the far end of the `memReadReq`/`memReadAddr`/`memData`/`memDataValid` path. Single outstanding access, no pipelining.

## Interface
Parameters:
- ARCH_BITS, 32, address width
- MEMORY_LINE_BITS, 128, line width (16 bytes)
- MEM_LINES, 4096, number of stored lines (power of two)
- MEM_LATENCY, 10, cycles from request acceptance to response (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- readReq  in  1  line-read request, level, held until readDataValid
- readAddr  in  ARCH_BITS  byte address of line; bits [3:0] ignored
- writeReq  in  1  line-write request, level, held until writeDone
- writeAddr  in  ARCH_BITS  byte address of line; bits [3:0] ignored
- writeData  in  MEMORY_LINE_BITS  line to store
- readData  out  MEMORY_LINE_BITS  returned line, valid only with readDataValid
- readDataValid  out  1  one-cycle pulse, read complete
- writeDone  out  1  one-cycle pulse, write committed
- busy  out  1  high in every state except IDLE

## Operation
- Line index = addr[3+log2(MEM_LINES):4]; higher bits ignored (addresses wrap modulo MEM_LINES×16 bytes).
- States: IDLE, RD_WAIT, WR_WAIT, RESP_RD, RESP_WR.
- IDLE: if writeReq → latch writeAddr/writeData, counter ← MEM_LATENCY−1, go WR_WAIT; else if readReq → latch readAddr, counter ← MEM_LATENCY−1, go RD_WAIT. Simultaneous requests: write wins; read stays pending and is served next.
- RD_WAIT/WR_WAIT: decrement counter; at 0 go RESP_RD/RESP_WR. With MEM_LATENCY=1, transition to RESP directly from IDLE.
- RESP_RD: readData ← array[latched index], readDataValid=1, go IDLE.
- RESP_WR: array[latched index] ← latched data, writeDone=1, go IDLE.
- Request inputs are sampled only in IDLE; changes during WAIT states are ignored (latched copies used).
- Requester must drop req in the cycle after the valid/done pulse; req high in IDLE is a new request.
- readData holds last returned line between responses.
- Array contents zero at time 0; not affected by rst.

## Timing
- Request first seen high in IDLE at edge N → valid/done pulse high during cycle N+MEM_LATENCY (registered output).
- Back-to-back: next request accepted at edge N+MEM_LATENCY+1; throughput one access per MEM_LATENCY+1 cycles.
- Read after write to same line returns the newly written data (write commits in RESP_WR before IDLE).
- Reset values: readData=0, readDataValid=0, writeDone=0, busy=0, state=IDLE, counter=0.
- rst mid-access: access aborted, no pulse, pending write not committed, array unchanged.

## Configuration
- MEMRESP_WRITE_EN defined: write path as above.
- Undefined: writeReq/writeAddr/writeData ignored, WR_WAIT/RESP_WR unreachable, writeDone tied 0; array read-only (zero unless preloaded by bench via hierarchical access). Matches current proc, which ties write enable low.

## Structure
- Shared package mem_pkg: ARCH_BITS, MEMORY_LINE_BITS, MEM_LATENCY default, state encoding constants, line-index width function.
- Sub-module mem_line_array: synchronous single-port line storage (one read or write per cycle, index + data + we), instantiated once.

## Test plan
- Reset then readReq, readAddr=0x00001000, MEM_LATENCY=10 → readDataValid exactly 10 cycles after acceptance, readData=0, single pulse, busy high 10 cycles.
- Write 0x00001010 ← 128'hDEADBEEF_00000001_00000002_00000003, then read 0x0000101C → writeDone pulse, read returns same line (offset bits ignored).
- writeReq and readReq together in IDLE → writeDone first; read accepted next cycle, readDataValid 11 cycles later, returns written data if same line.
- rst asserted 4 cycles into a write to 0x2000 → no writeDone, outputs at reset values, later read of 0x2000 returns 0.
- MEM_LATENCY=1, back-to-back reads 0x1000,0x1010 → valid at N+1 and N+3.
- MEMRESP_WRITE_EN undefined, writeReq=1 → writeDone stays 0, busy stays 0, array unchanged.
